// File: rtl/riscv_dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package riscv_dmem_pkg;

  localparam int WORD_BYTES    = 4;
  localparam int DEF_MEM_BYTES = 8192;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } dmem_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } dmem_owner_t;

  // A request is rejected when it is not word aligned or falls past the memory.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned mem_bytes);
    logic lsb_bad;
    logic range_bad;
    lsb_bad   = ((addr & 32'(WORD_BYTES - 1)) != 32'd0);
    range_bad = (addr >= 32'(mem_bytes));
    return lsb_bad | range_bad;
  endfunction

endpackage

// File: rtl/riscv_dmem_prio.sv
// Winner select for the two requesters: core first, but DMA is forced once
// the core has been granted MAX_SKIP times in a row while DMA was waiting.
module riscv_dmem_prio
  import riscv_dmem_pkg::*;
#(
  parameter int MAX_SKIP = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c_valid,
  input  logic d_valid,
  input  logic grant_en,
  output logic c_grant,
  output logic d_grant
);

  localparam int            SW       = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
  localparam logic [SW-1:0] SKIP_MAX = SW'(MAX_SKIP);
  localparam logic [SW-1:0] SKIP_ONE = SW'(1);

  logic [SW-1:0] skip_cnt_q;
  logic [SW-1:0] skip_cnt_d;
  logic          force_dma_s;

  // Pick at most one winner among the valid requesters.
  always_comb begin
    force_dma_s = (skip_cnt_q == SKIP_MAX);
    c_grant     = 1'b0;
    d_grant     = 1'b0;
    if (grant_en) begin
      if (c_valid && (!d_valid || !force_dma_s)) begin
        c_grant = 1'b1;
      end else if (d_valid) begin
        d_grant = 1'b1;
      end else begin
        c_grant = 1'b0;
      end
    end else begin
      d_grant = 1'b0;
    end
  end

  // Count core wins that made DMA wait; any DMA win clears it, saturating at the limit.
  always_comb begin
    skip_cnt_d = skip_cnt_q;
    if (d_grant) begin
      skip_cnt_d = {SW{1'b0}};
    end else if (c_grant && d_valid && (skip_cnt_q != SKIP_MAX)) begin
      skip_cnt_d = skip_cnt_q + SKIP_ONE;
    end else begin
      skip_cnt_d = skip_cnt_q;
    end
  end

  // Skip counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skip_cnt_q <= {SW{1'b0}};
    end else begin
      skip_cnt_q <= skip_cnt_d;
    end
  end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Shares one single-port data memory between the core LSU (c_*) and a
// DMA/debug loader (d_*). One word request is in flight at a time; the
// owner gets a one-cycle response pulse when it completes.
module riscv_dmem_arbiter
  import riscv_dmem_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int RD_LAT    = 1,
  parameter int MAX_SKIP  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         c_valid,
  input  logic                         c_we,
  input  logic [31:0]                  c_addr,
  input  logic [31:0]                  c_wdata,
  input  logic [3:0]                   c_be,
  output logic                         c_ready,
  output logic                         c_rsp_valid,
  output logic                         c_rsp_err,
  input  logic                         d_valid,
  input  logic                         d_we,
  input  logic [31:0]                  d_addr,
  input  logic [31:0]                  d_wdata,
  input  logic [3:0]                   d_be,
  output logic                         d_ready,
  output logic                         d_rsp_valid,
  output logic                         d_rsp_err,
  output logic [31:0]                  rsp_rdata,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [$clog2(MEM_BYTES)-1:0] mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic [3:0]                   mem_be,
  input  logic [31:0]                  mem_rdata
);

  localparam int         AW        = $clog2(MEM_BYTES);
  localparam int         OFS_W     = $clog2(WORD_BYTES);
  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  dmem_state_t state_q, state_d;
  dmem_owner_t owner_q, owner_d;
  logic        we_q, we_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        c_grant_s, d_grant_s, grant_en_s, accept_s;
  logic        sel_we_s, sel_bad_s;
  logic [31:0] sel_addr_s, sel_wdata_s;
  logic [3:0]  sel_be_s;
  logic        issue_nx_s, rsp_nx_s, err_nx_s;

  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_be_q;
  logic          c_rsp_q, d_rsp_q, c_err_q, d_err_q;

  // Requests are only taken while idle and out of reset, so a reset never
  // leaves a half-accepted transaction behind.
  assign grant_en_s = (state_q == IDLE) && rst_n;

  riscv_dmem_prio #(
    .MAX_SKIP (MAX_SKIP)
  ) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .c_valid  (c_valid),
    .d_valid  (d_valid),
    .grant_en (grant_en_s),
    .c_grant  (c_grant_s),
    .d_grant  (d_grant_s)
  );

  assign accept_s = c_grant_s | d_grant_s;
  assign c_ready  = c_grant_s;
  assign d_ready  = d_grant_s;

  // Route the winning requester's fields toward the issue path.
  always_comb begin
    if (d_grant_s) begin
      sel_we_s    = d_we;
      sel_addr_s  = d_addr;
      sel_wdata_s = d_wdata;
      sel_be_s    = d_be;
    end else begin
      sel_we_s    = c_we;
      sel_addr_s  = c_addr;
      sel_wdata_s = c_wdata;
      sel_be_s    = c_be;
    end
    sel_bad_s = addr_bad(sel_addr_s, MEM_BYTES);
  end

  // Next-state logic for the request sequencer.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          owner_d = d_grant_s ? OWN_DMA : OWN_CORE;
          we_d    = sel_we_s;
          if (sel_bad_s) begin
            state_d = ERR;
            rdata_d = 32'h0000_0000;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        wait_cnt_d = 2'd0;
        if (we_q) begin
          state_d = RESP;
          rdata_d = 32'h0000_0000;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode which strobes the next cycle will carry so they can be registered.
  always_comb begin
    issue_nx_s = (state_d == ISSUE);
    rsp_nx_s   = (state_d == RESP) || (state_d == ERR);
    err_nx_s   = (state_d == ERR);
  end

  // Sequencer state and the latched request attributes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CORE;
      we_q       <= 1'b0;
      wait_cnt_q <= 2'd0;
      rdata_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  // Memory port and response strobes; the issue fields are captured at accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
      mem_be_q    <= 4'h0;
      c_rsp_q     <= 1'b0;
      d_rsp_q     <= 1'b0;
      c_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      mem_en_q    <= issue_nx_s;
      mem_we_q    <= issue_nx_s & sel_we_s;
      mem_addr_q  <= issue_nx_s ? {sel_addr_s[AW-1:OFS_W], {OFS_W{1'b0}}} : {AW{1'b0}};
      mem_wdata_q <= issue_nx_s ? sel_wdata_s : 32'h0000_0000;
      mem_be_q    <= (issue_nx_s && sel_we_s) ? sel_be_s : 4'h0;
      c_rsp_q     <= rsp_nx_s && (owner_d == OWN_CORE);
      d_rsp_q     <= rsp_nx_s && (owner_d == OWN_DMA);
      c_err_q     <= err_nx_s && (owner_d == OWN_CORE);
      d_err_q     <= err_nx_s && (owner_d == OWN_DMA);
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign c_rsp_valid = c_rsp_q;
  assign d_rsp_valid = d_rsp_q;
  assign c_rsp_err   = c_err_q;
  assign d_rsp_err   = d_err_q;
  assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: directed table, multi-cycle sequences and a
// randomized run checked against a transaction-level latency model.
`timescale 1ns/1ps
module tb_riscv_dmem_arbiter;
  import riscv_dmem_pkg::*;

  localparam int MEMB  = 8192;
  localparam int MSKIP = 4;
  localparam int RDL   = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic c_valid, c_we, d_valid, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;
  logic [3:0] c_be, d_be;
  logic c_ready, d_ready, c_rsp_valid, d_rsp_valid, c_rsp_err, d_rsp_err;
  logic [31:0] rsp_rdata, mem_wdata;
  logic mem_en, mem_we;
  logic [12:0] mem_addr;
  logic [3:0] mem_be;

  logic x_c_valid, x_c_we, x_d_valid, x_d_we;
  logic [31:0] x_c_addr, x_c_wdata, x_d_addr, x_d_wdata, x_mem_rdata;
  logic [3:0] x_c_be, x_d_be;
  logic x_c_ready, x_d_ready, x_c_rsp_valid, x_d_rsp_valid, x_c_rsp_err, x_d_rsp_err;
  logic [31:0] x_rsp_rdata, x_mem_wdata;
  logic x_mem_en, x_mem_we;
  logic [12:0] x_mem_addr;
  logic [3:0] x_mem_be;

  riscv_dmem_arbiter #(.MEM_BYTES(MEMB), .RD_LAT(RDL), .MAX_SKIP(MSKIP)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_valid(c_valid), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_ready(c_ready), .c_rsp_valid(c_rsp_valid), .c_rsp_err(c_rsp_err),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rsp_valid(d_rsp_valid), .d_rsp_err(d_rsp_err),
    .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  riscv_dmem_arbiter #(.MEM_BYTES(MEMB), .RD_LAT(3), .MAX_SKIP(MSKIP)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .c_valid(x_c_valid), .c_we(x_c_we), .c_addr(x_c_addr), .c_wdata(x_c_wdata), .c_be(x_c_be),
    .c_ready(x_c_ready), .c_rsp_valid(x_c_rsp_valid), .c_rsp_err(x_c_rsp_err),
    .d_valid(x_d_valid), .d_we(x_d_we), .d_addr(x_d_addr), .d_wdata(x_d_wdata), .d_be(x_d_be),
    .d_ready(x_d_ready), .d_rsp_valid(x_d_rsp_valid), .d_rsp_err(x_d_rsp_err),
    .rsp_rdata(x_rsp_rdata), .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr),
    .mem_wdata(x_mem_wdata), .mem_be(x_mem_be), .mem_rdata(x_mem_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic        dma;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        exp_err;
    int          exp_rsp;
    logic [12:0] exp_maddr;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        v;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    logic        mem;
    logic        we;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        crsp;
    logic        drsp;
    logic        err;
    logic [31:0] rdata;
  } slot_t;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%08h, want 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] rhash(input int t);
    return (32'(t) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic idle_inputs();
    c_valid = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_be = 4'h0;
    d_valid = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    mem_rdata = 32'h0;
    x_c_valid = 1'b0; x_c_we = 1'b0; x_c_addr = 32'h0; x_c_wdata = 32'h0; x_c_be = 4'h0;
    x_d_valid = 1'b0; x_d_we = 1'b0; x_d_addr = 32'h0; x_d_wdata = 32'h0; x_d_be = 4'h0;
    x_mem_rdata = 32'h0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, 32'({c_ready, d_ready, x_c_ready, x_d_ready}), 32'h0);
    chk({tag, "_rsp"}, 32'({c_rsp_valid, d_rsp_valid, c_rsp_err, d_rsp_err}), 32'h0);
    chk({tag, "_rsp3"}, 32'({x_c_rsp_valid, x_d_rsp_valid, x_c_rsp_err, x_d_rsp_err}), 32'h0);
    chk({tag, "_mem"}, 32'({mem_en, mem_we, mem_be, mem_addr}), 32'h0);
    chk({tag, "_mem3"}, 32'({x_mem_en, x_mem_we, x_mem_be, x_mem_addr}), 32'h0);
    chk({tag, "_wdata"}, mem_wdata | x_mem_wdata, 32'h0);
    chk({tag, "_rdata"}, rsp_rdata | x_rsp_rdata, 32'h0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    chk_quiet("reset");
  endtask

  task automatic new_req(output req_t r);
    int sel;
    sel     = $urandom_range(0, 9);
    r.v     = ($urandom_range(0, 9) < 6);
    r.we    = 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    r.be    = 4'($urandom_range(0, 15));
    if (sel == 0) begin
      r.addr = {19'h0, 11'($urandom_range(0, 2047)), 2'($urandom_range(1, 3))};
    end else if (sel == 1) begin
      r.addr = 32'(MEMB) + (32'($urandom_range(0, 4095)) << 2);
    end else if (sel == 2) begin
      r.addr = $urandom | 32'h8000_0000;
    end else begin
      r.addr = {19'h0, 11'($urandom_range(0, 2047)), 2'b00};
    end
  endtask

  vec_t  vt [0:7];
  slot_t slots [0:15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    string exp_order;
    string got;
    req_t  rc, rd;
    int    free_at, skips, ng, guard;
    logic  after_d;

    vt[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 2, 13'h0010, 32'h0};
    vt[1] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 3, 13'h0010, 32'hDEAD_BEEF};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'h1111_1111, 1'b1, 1, 13'h0000, 32'h0};
    vt[3] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'h0, 32'h2222_2222, 1'b1, 1, 13'h0000, 32'h0};
    vt[4] = '{1'b1, 1'b1, 32'h0000_1FFC, 32'h1234_5678, 4'h3, 32'h0,         1'b0, 2, 13'h1FFC, 32'h0};
    vt[5] = '{1'b1, 1'b0, 32'h0000_1FFC, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0, 3, 13'h1FFC, 32'hCAFE_F00D};
    vt[6] = '{1'b0, 1'b1, 32'h0000_0002, 32'h5555_AAAA, 4'hF, 32'h0,         1'b1, 1, 13'h0000, 32'h0};
    vt[7] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h3333_3333, 1'b1, 1, 13'h0000, 32'h0};

    // ---------------- reset state and directed table ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      idle_inputs();
      mem_rdata = vt[i].rd;
      if (vt[i].dma) begin
        d_valid = 1'b1; d_we = vt[i].we; d_addr = vt[i].addr; d_wdata = vt[i].wdata; d_be = vt[i].be;
      end else begin
        c_valid = 1'b1; c_we = vt[i].we; c_addr = vt[i].addr; c_wdata = vt[i].wdata; c_be = vt[i].be;
      end
      #2;
      chk("tbl_c_ready", 32'(c_ready), 32'(!vt[i].dma));
      chk("tbl_d_ready", 32'(d_ready), 32'(vt[i].dma));
      tick();
      c_valid = 1'b0;
      d_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        #2;
        chk("tbl_mem_en", 32'(mem_en), 32'(!vt[i].exp_err && k == 1));
        if (!vt[i].exp_err && k == 1) begin
          chk("tbl_mem_we", 32'(mem_we), 32'(vt[i].we));
          chk("tbl_mem_addr", 32'(mem_addr), 32'(vt[i].exp_maddr));
          chk("tbl_mem_be", 32'(mem_be), vt[i].we ? 32'(vt[i].be) : 32'h0);
          if (vt[i].we) chk("tbl_mem_wdata", mem_wdata, vt[i].wdata);
        end
        chk("tbl_c_rsp", 32'(c_rsp_valid), 32'(k == vt[i].exp_rsp && !vt[i].dma));
        chk("tbl_d_rsp", 32'(d_rsp_valid), 32'(k == vt[i].exp_rsp && vt[i].dma));
        if (k == vt[i].exp_rsp) begin
          chk("tbl_c_err", 32'(c_rsp_err), 32'(vt[i].exp_err && !vt[i].dma));
          chk("tbl_d_err", 32'(d_rsp_err), 32'(vt[i].exp_err && vt[i].dma));
          chk("tbl_rdata", rsp_rdata, vt[i].exp_rdata);
        end
        if (k < 4) tick();
      end
    end

    // ---------------- both requesters held: anti-starvation order ----------------
    do_reset();
    tick();
    c_valid = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'hC0C0_C0C0; c_be = 4'hF;
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hD0D0_D0D0; d_be = 4'hF;
    exp_order = "CCCCDCCCCD";
    ng = 0;
    guard = 0;
    after_d = 1'b0;
    while (ng < 10 && guard < 200) begin
      #2;
      if (after_d) chk("arb_skip_cleared", 32'(dut.u_prio.skip_cnt_q), 32'h0);
      after_d = 1'b0;
      chk("arb_one_ready", 32'(c_ready & d_ready), 32'h0);
      if (c_ready || d_ready) begin
        chk("arb_order", c_ready ? 32'h43 : 32'h44, 32'(exp_order[ng]));
        if (d_ready) begin
          chk("arb_skip_at_d", 32'(dut.u_prio.skip_cnt_q), 32'(MSKIP));
          after_d = 1'b1;
        end
        ng++;
      end
      tick();
      guard++;
    end
    chk("arb_grant_count", 32'(ng), 32'd10);
    idle_inputs();
    tick(); tick(); tick();

    // ---------------- reset during WAIT of a core load ----------------
    do_reset();
    tick();
    c_valid = 1'b1; c_we = 1'b0; c_addr = 32'h10; mem_rdata = 32'h1111_2222;
    #2;
    chk("rstw_ready", 32'(c_ready), 32'h1);
    tick();
    c_valid = 1'b0;
    #2;
    chk("rstw_issue", 32'(mem_en), 32'h1);
    tick();
    rst_n = 1'b0;
    #2;
    chk("rstw_wait_no_rsp", 32'(c_rsp_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    mem_rdata = 32'h0;
    #2;
    chk("rstw_state", 32'(dut.state_q), 32'(IDLE));
    chk_quiet("rstw_after");
    tick();
    #2;
    chk("rstw_no_late_rsp", 32'({c_rsp_valid, d_rsp_valid}), 32'h0);
    tick();
    c_valid = 1'b1; c_we = 1'b1; c_addr = 32'h20; c_wdata = 32'h0BAD_CAFE; c_be = 4'h5;
    #2;
    chk("rstw_fresh_ready", 32'(c_ready), 32'h1);
    tick();
    c_valid = 1'b0;
    #2;
    chk("rstw_fresh_mem", 32'({mem_en, mem_we, mem_be, mem_addr}), 32'({1'b1, 1'b1, 4'h5, 13'h0020}));
    chk("rstw_fresh_wdata", mem_wdata, 32'h0BAD_CAFE);
    tick();
    #2;
    chk("rstw_fresh_rsp", 32'({c_rsp_valid, c_rsp_err}), 32'h2);

    // ---------------- RD_LAT=3 build: core load ----------------
    do_reset();
    tick();
    x_c_valid = 1'b1; x_c_we = 1'b0; x_c_addr = 32'h24; x_mem_rdata = 32'hBAD0_BAD0;
    #2;
    chk("lat3_ready", 32'(x_c_ready), 32'h1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      x_c_valid = 1'b0;
      x_mem_rdata = (k == 4) ? 32'h600D_F00D : (32'hBAD0_0000 | 32'(k));
      #2;
      chk("lat3_mem_en", 32'(x_mem_en), 32'(k == 1));
      if (k == 1) chk("lat3_mem_addr", 32'(x_mem_addr), 32'h24);
      chk("lat3_rsp", 32'(x_c_rsp_valid), 32'(k == 5));
      if (k == 5) chk("lat3_rdata", x_rsp_rdata, 32'h600D_F00D);
    end

    // ---------------- randomized run against the latency model ----------------
    do_reset();
    tick();
    free_at = cyc;
    skips = 0;
    rc = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
    rd = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
    for (int s = 0; s < 16; s++) slots[s] = '{default: '0};
    for (int n = 0; n < 3000; n++) begin
      logic cg, dg, bad, rsp_any;
      req_t w;
      int   sl, t;
      t = cyc;
      if (!rc.v) new_req(rc);
      else if ($urandom_range(0, 19) == 0) rc.v = 1'b0;
      if (!rd.v) new_req(rd);
      else if ($urandom_range(0, 19) == 0) rd.v = 1'b0;
      c_valid = rc.v; c_we = rc.we; c_addr = rc.addr; c_wdata = rc.wdata; c_be = rc.be;
      d_valid = rd.v; d_we = rd.we; d_addr = rd.addr; d_wdata = rd.wdata; d_be = rd.be;
      mem_rdata = rhash(t);
      #2;
      cg = (t >= free_at) && rc.v && (!rd.v || skips < MSKIP);
      dg = (t >= free_at) && rd.v && !cg;
      chk("rnd_c_ready", 32'(c_ready), 32'(cg));
      chk("rnd_d_ready", 32'(d_ready), 32'(dg));
      sl = t % 16;
      chk("rnd_mem_en", 32'(mem_en), 32'(slots[sl].mem));
      if (slots[sl].mem) begin
        chk("rnd_mem_we", 32'(mem_we), 32'(slots[sl].we));
        chk("rnd_mem_addr", 32'(mem_addr), 32'(slots[sl].addr));
        chk("rnd_mem_be", 32'(mem_be), 32'(slots[sl].be));
        if (slots[sl].we) chk("rnd_mem_wdata", mem_wdata, slots[sl].wdata);
      end
      chk("rnd_c_rsp", 32'(c_rsp_valid), 32'(slots[sl].crsp));
      chk("rnd_d_rsp", 32'(d_rsp_valid), 32'(slots[sl].drsp));
      rsp_any = slots[sl].crsp | slots[sl].drsp;
      if (rsp_any) begin
        chk("rnd_c_err", 32'(c_rsp_err), 32'(slots[sl].err & slots[sl].crsp));
        chk("rnd_d_err", 32'(d_rsp_err), 32'(slots[sl].err & slots[sl].drsp));
        chk("rnd_rdata", rsp_rdata, slots[sl].rdata);
      end
      slots[sl] = '{default: '0};
      if (cg || dg) begin
        w = cg ? rc : rd;
        bad = (w.addr[1:0] != 2'b00) || (w.addr >= 32'(MEMB));
        if (bad) begin
          slots[(t + 1) % 16].crsp = cg;
          slots[(t + 1) % 16].drsp = dg;
          slots[(t + 1) % 16].err  = 1'b1;
          free_at = t + 2;
        end else begin
          slots[(t + 1) % 16].mem   = 1'b1;
          slots[(t + 1) % 16].we    = w.we;
          slots[(t + 1) % 16].addr  = 13'(w.addr) & 13'h1FFC;
          slots[(t + 1) % 16].wdata = w.wdata;
          slots[(t + 1) % 16].be    = w.we ? w.be : 4'h0;
          if (w.we) begin
            slots[(t + 2) % 16].crsp = cg;
            slots[(t + 2) % 16].drsp = dg;
            free_at = t + 3;
          end else begin
            slots[(t + 2 + RDL) % 16].crsp  = cg;
            slots[(t + 2 + RDL) % 16].drsp  = dg;
            slots[(t + 2 + RDL) % 16].rdata = rhash(t + 1 + RDL);
            free_at = t + 3 + RDL;
          end
        end
        if (dg) skips = 0;
        else if (rd.v && skips < MSKIP) skips = skips + 1;
        if (cg) rc.v = 1'b0;
        else rd.v = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_arbiter.md
Name: riscv_dmem_arbiter

Overview:
Sequences and shares the single-port byte-addressed data memory between two requesters: the core load/store unit (port c_) and a DMA/debug loader (port d_). Accepts one word request at a time through a valid/ready handshake and drives the memory port (enable, write enable, byte enables). Returns a one-cycle response pulse to the owning requester. Core has fixed priority, bounded by an anti-starvation counter for DMA.

Parameters:
MEM_BYTES, 8192, memory size in bytes; addresses >= MEM_BYTES are errors
RD_LAT, 1, cycles from the issue cycle (mem_en=1) to mem_rdata valid; legal range 1..4
MAX_SKIP, 4, consecutive core grants allowed while DMA is waiting before DMA is forced

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
c_valid / d_valid  in  1  request valid, held stable until ready
c_we / d_we  in  1  1=store, 0=load
c_addr / d_addr  in  32  byte address
c_wdata / d_wdata  in  32  store data
c_be / d_be  in  4  byte enables, stores only
c_ready / d_ready  out  1  request accepted this cycle
c_rsp_valid / d_rsp_valid  out  1  one-cycle response pulse
c_rsp_err / d_rsp_err  out  1  qualified by rsp_valid: misaligned or out of range
rsp_rdata  out  32  load data, shared, qualified by either rsp_valid
mem_en  out  1  memory access strobe, one cycle per request
mem_we  out  1  write enable, only with mem_en
mem_addr  out  $clog2(MEM_BYTES)  word-aligned byte address
mem_wdata  out  32  store data
mem_be  out  4  byte enables, 0 on loads
mem_rdata  in  32  memory read data

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, all outputs 0, skip_cnt 0. Any in-flight request is dropped with no response. Resumes on the first edge with rst_n=1.
- FSM states and transitions:
  - IDLE: ready is combinational on valid. At most one of c_ready/d_ready is high. The winner's fields are latched. Go to ERR if addr[1:0]!=0 or addr>=MEM_BYTES; otherwise go to ISSUE.
  - ISSUE: mem_en=1 for exactly one cycle with the latched fields. Writes go to RESP; reads go to WAIT.
  - WAIT: lasts RD_LAT cycles. On the last one, mem_rdata is registered into rsp_rdata. Then go to RESP.
  - ERR: the owner's rsp_valid=1 and rsp_err=1 with rdata=0 (same cycle as the error response). Then go to IDLE.
  - RESP: the owner's rsp_valid=1 for one cycle, rsp_err=0. Then go to IDLE. No acceptance happens in RESP or ERR.
- Latency (accept cycle = T):
  - Store: mem_en at T+1, response at T+2.
  - Load: mem_en at T+1, response at T+2+RD_LAT (T+3 with the default).
  - Error: response at T+1, no memory access.
- rsp_rdata holds its value until the next load completes. It is 0 for stores.
- Arbitration in IDLE:
  - Only one valid: that requester wins.
  - Both valid: core wins unless skip_cnt==MAX_SKIP.
  - skip_cnt increments on a core grant while d_valid=1. It clears on any DMA grant and saturates at MAX_SKIP.
- mem_addr = latched addr[$clog2(MEM_BYTES)-1:0] with bits [1:0] forced to 0. mem_be = latched be when writing, otherwise 0.
- Simultaneous events: a new valid arriving during ISSUE/WAIT/RESP waits, with ready=0. A requester may drop valid before ready; that is harmless.

Decomposition:
- Package riscv_dmem_pkg:
  - typedef enum dmem_state_t {IDLE, ISSUE, WAIT, RESP, ERR}
  - typedef enum dmem_owner_t {OWN_CORE, OWN_DMA}
  - constants WORD_BYTES=4 and the default MEM_BYTES
- Sub-module riscv_dmem_prio: combinational winner select plus the registered skip_cnt. Inputs c_valid, d_valid, grant_en; outputs c_grant, d_grant.

Test Plan:
1. Core store addr=0x10, wdata=0xDEADBEEF, be=4'hF at T → c_ready at T; mem_en=1, mem_we=1, mem_addr=0x10 at T+1; c_rsp_valid at T+2, err=0.
2. Core load addr=0x10 with mem_rdata=0xDEADBEEF driven at T+2 (RD_LAT=1) → c_rsp_valid at T+3, rsp_rdata=0xDEADBEEF, d_rsp_valid never high.
3. c_valid and d_valid held high continuously, MAX_SKIP=4 → grant order C,C,C,C,D,C,C,C,C,D; skip_cnt returns to 0 after each D.
4. d_ load addr=0x13 → d_ready, then d_rsp_valid=1 and d_rsp_err=1 the next cycle; no mem_en. Load addr=0x2000 gives the same result.
5. rst_n=0 during WAIT of a core load → next cycle state IDLE, all outputs 0, no c_rsp_valid; a fresh request after reset completes normally.
6. RD_LAT=3 build, core load → mem_en at T+1, c_rsp_valid at T+5 with data sampled at T+4.
